// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: shift direction encoding and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ASL = 2'b11
    } shift_dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational multistage barrel shifter; stage i shifts by 2**i when amt[i] is set.
module shift_core
    import shift_pkg::*;
#(
    parameter int NUM_STAGE = 3,
    localparam int W        = 2 ** NUM_STAGE
) (
    input  logic [W-1:0]         data_in,
    input  logic [NUM_STAGE-1:0] amt,
    input  shift_dir_e           dir,
    output logic [W-1:0]         data_out
);

    logic [W-1:0] stage_val;

    always_comb begin
        stage_val = data_in;
        for (int unsigned i = 0; i < NUM_STAGE; i++) begin
            if (amt[i]) begin
                unique case (dir)
                    SH_LSR:  stage_val = stage_val >> (1 << i);
                    SH_ASR:  stage_val = $unsigned($signed(stage_val) >>> (1 << i));
                    default: stage_val = stage_val << (1 << i);
                endcase
            end
        end
        data_out = stage_val;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared shifter; one operation in flight at a time.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_STAGE = 3,
    parameter int NUM_REQ   = 4,
    localparam int W        = 2 ** NUM_STAGE,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*W-1:0]           req_data,
    input  logic [NUM_REQ*NUM_STAGE-1:0]   req_amt,
    input  logic [NUM_REQ*2-1:0]           req_dir,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [W-1:0]                   rsp_data,
    output logic [IDW-1:0]                 rsp_id
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [W-1:0]         op_data_q, op_data_d;
    logic [NUM_STAGE-1:0] op_amt_q, op_amt_d;
    shift_dir_e           op_dir_q, op_dir_d;
    logic [IDW-1:0]       op_id_q, op_id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [W-1:0]         rsp_data_q, rsp_data_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;

    logic [W-1:0]         shift_res;
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    int unsigned          cand;

    // Scan from rr_ptr upward, wrapping, and keep the first valid index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % 32'(NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    shift_core #(
        .NUM_STAGE (NUM_STAGE)
    ) u_shift_core (
        .data_in  (op_data_q),
        .amt      (op_amt_q),
        .dir      (op_dir_q),
        .data_out (shift_res)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_data_d   = op_data_q;
        op_amt_d    = op_amt_q;
        op_dir_d    = op_dir_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_data_d = req_data[int'(win_idx)*W +: W];
                    op_amt_d  = req_amt[int'(win_idx)*NUM_STAGE +: NUM_STAGE];
                    op_dir_d  = shift_dir_e'(req_dir[int'(win_idx)*2 +: 2]);
                    op_id_d   = win_idx;
                    rr_ptr_d  = (int'(win_idx) == NUM_REQ - 1) ? '0 : IDW'(win_idx + 1'b1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = shift_res;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_data_q   <= '0;
            op_amt_q    <= '0;
            op_dir_q    <= SH_LSL;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_data_q   <= op_data_d;
            op_amt_q    <= op_amt_d;
            op_dir_q    <= op_dir_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: vector table, round-robin, stall and mid-flight reset sequences.
module tb_shift_arbiter;

    localparam int NUM_STAGE = 3;
    localparam int NUM_REQ   = 4;
    localparam int W         = 8;
    localparam int IDW       = 2;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*W-1:0]         req_data;
    logic [NUM_REQ*NUM_STAGE-1:0] req_amt;
    logic [NUM_REQ*2-1:0]         req_dir;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [W-1:0]                 rsp_data;
    logic [IDW-1:0]               rsp_id;

    shift_arbiter #(
        .NUM_STAGE (NUM_STAGE),
        .NUM_REQ   (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
        logic [2:0]  amt;
        logic [1:0]  dir;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response side of the scoreboard: every accepted response must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    task automatic load_slot(input int unsigned id, input logic [7:0] d,
                             input logic [2:0] a, input logic [1:0] dr);
        req_data[id*W +: W]                 = d;
        req_amt[id*NUM_STAGE +: NUM_STAGE]  = a;
        req_dir[id*2 +: 2]                  = dr;
    endtask

    // Drive one request, wait for its grant, push the expectation; returns in the EXEC cycle.
    task automatic issue(input int unsigned id, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] dr, input logic [7:0] exp, input bit push,
                         output bit ok);
        logic [NUM_REQ-1:0] onehot;
        ok = 1'b0;
        onehot = '0;
        onehot[id] = 1'b1;
        req_data = $urandom;
        req_amt  = 12'($urandom);
        req_dir  = 8'($urandom);
        load_slot(id, d, a, dr);
        req_valid = onehot;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("grant_timeout", 32'(req_ready), 32'(onehot));
        end else begin
            check("grant_onehot", 32'(req_ready), 32'(onehot));
            if (push) sb.push_back('{id: IDW'(id), data: exp});
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        issue(v.id, v.data, v.amt, v.dir, v.exp, 1'b1, ok);
        if (ok) begin
            @(negedge clk);
            check("exec_no_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("resp_valid_lat2", 32'(rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[14];

    initial begin
        bit ok;
        int last_cyc;
        int cyc;
        int g;
        int exp_order[5];

        vecs[0]  = '{id: 0, data: 8'h96, amt: 3'd3, dir: 2'b00, exp: 8'hB0};
        vecs[1]  = '{id: 1, data: 8'h96, amt: 3'd2, dir: 2'b10, exp: 8'hE5};
        vecs[2]  = '{id: 1, data: 8'h96, amt: 3'd2, dir: 2'b01, exp: 8'h25};
        vecs[3]  = '{id: 1, data: 8'h96, amt: 3'd7, dir: 2'b01, exp: 8'h01};
        vecs[4]  = '{id: 2, data: 8'h5A, amt: 3'd0, dir: 2'b00, exp: 8'h5A};
        vecs[5]  = '{id: 3, data: 8'h5A, amt: 3'd0, dir: 2'b01, exp: 8'h5A};
        vecs[6]  = '{id: 0, data: 8'h5A, amt: 3'd0, dir: 2'b10, exp: 8'h5A};
        vecs[7]  = '{id: 1, data: 8'h5A, amt: 3'd0, dir: 2'b11, exp: 8'h5A};
        vecs[8]  = '{id: 2, data: 8'h96, amt: 3'd7, dir: 2'b10, exp: 8'hFF};
        vecs[9]  = '{id: 3, data: 8'h81, amt: 3'd1, dir: 2'b11, exp: 8'h02};
        vecs[10] = '{id: 3, data: 8'h6C, amt: 3'd5, dir: 2'b10, exp: 8'h03};
        vecs[11] = '{id: 0, data: 8'h01, amt: 3'd7, dir: 2'b00, exp: 8'h80};
        vecs[12] = '{id: 2, data: 8'hF0, amt: 3'd4, dir: 2'b01, exp: 8'h0F};
        vecs[13] = '{id: 2, data: 8'h80, amt: 3'd1, dir: 2'b10, exp: 8'hC0};

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        for (int i = 0; i < NUM_REQ; i++) load_slot(i, 8'(8'h11 * (i + 1)), 3'd1, 2'b00);

        // Reset state with every requester asserting.
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin from reset: 0,1,2,3,0 each three cycles apart.
        exp_order = '{0, 1, 2, 3, 0};
        g = 0;
        last_cyc = 0;
        for (cyc = 0; cyc < 30 && g < 5; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_grant", 32'(req_ready), 32'(1 << exp_order[g]));
                if (g > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                sb.push_back('{id: IDW'(exp_order[g]), data: 8'(8'h22 * (exp_order[g] + 1))});
                last_cyc = cyc;
                g++;
            end
        end
        check("rr_grant_count", 32'(g), 32'd5);
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
        check("rr_drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Consumer stall for five cycles in RESP.
        rsp_ready = 1'b0;
        issue(1, 8'h96, 3'd2, 2'b10, 8'hE5, 1'b1, ok);
        req_valid = '1;
        @(negedge clk);
        check("stall_exec_valid", 32'(rsp_valid), 32'd0);
        check("stall_exec_ready", 32'(req_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'hE5);
            check("stall_id", 32'(rsp_id), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("stall_accept_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("stall_idle_valid", 32'(rsp_valid), 32'd0);
        check("stall_drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset while EXEC: in-flight op from req 2 is dropped, pointer returns to 0.
        issue(2, 8'hAA, 3'd1, 2'b01, 8'h55, 1'b0, ok);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) load_slot(i, 8'h5A, 3'd1, 2'b01);
        req_valid = '1;
        @(negedge clk);
        check("mrst_req_ready", 32'(req_ready), 32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rsp_valid_idle", 32'(rsp_valid), 32'd0);
        check("mrst_first_grant", 32'(req_ready), 32'b0001);
        if (req_ready == 4'b0001) sb.push_back('{id: IDW'(0), data: 8'h2D});
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("mrst_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("mrst_resp_valid", 32'(rsp_valid), 32'd1);

        repeat (4) @(negedge clk);
        check("final_drain", 32'(sb.size()), 32'd0);
        check("final_idle_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
